// File: rtl/lii_stream_adapter.sv
// LII <-> HLS kernel adapter: dst-filtered input unpacked into per-lane FWFT FIFOs, output lanes joined into one registered beat.
// Input: k_in_tvalid one cycle after accept, lii_in_tready low while any lane FIFO is full. Output: one registered stage, held lanes stall kernel.
module lii_lane_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdat_i,
  input  logic         pop_i,
  output logic [W-1:0] rdat_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         do_push, do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdat_o  = mem_q[rd_q[AW-1:0]];
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdat_i;
  end
endmodule

module lii_stream_adapter #(
  parameter int         NIN     = 5,
  parameter int         NOUT    = 1,
  parameter int         IW      = 17,
  parameter int         OW      = 32,
  parameter int         PW      = 128,
  parameter int         DEPTH   = 4,
  parameter logic [7:0] NODE_ID = 8'h00,
  parameter logic [7:0] DEST_ID = 8'h00
) (
  input  logic                aclk,
  input  logic                arst,
  input  logic [PW-1:0]       lii_in_tdata,
  input  logic                lii_in_tvalid,
  output logic                lii_in_tready,
  input  logic [7:0]          lii_in_src,
  input  logic [7:0]          lii_in_dst,
  output logic [PW-1:0]       lii_out_tdata,
  output logic                lii_out_tvalid,
  input  logic                lii_out_tready,
  output logic [7:0]          lii_out_src,
  output logic [7:0]          lii_out_dst,
  output logic [NIN*IW-1:0]   k_in_tdata,
  output logic [NIN-1:0]      k_in_tvalid,
  input  logic [NIN-1:0]      k_in_tready,
  input  logic [NOUT*OW-1:0]  k_out_tdata,
  input  logic [NOUT-1:0]     k_out_tvalid,
  output logic [NOUT-1:0]     k_out_tready,
  output logic [15:0]         drop_cnt,
  output logic                ce
);
  logic            own_beat, in_hs, drop_beat;
  logic [NIN-1:0]  lane_full, lane_empty, lane_pop;
  logic [15:0]     drop_cnt_q;
  logic            unused_src;

  assign unused_src    = ^lii_in_src;
  assign own_beat      = (lii_in_dst == NODE_ID);
  assign lii_in_tready = own_beat ? ~|lane_full : 1'b1;
  assign in_hs         = lii_in_tvalid & own_beat & ~|lane_full;
  assign drop_beat     = lii_in_tvalid & ~own_beat;

  // Every lane is written on the same handshake; each drains at its own pace.
  for (genvar i = 0; i < NIN; i++) begin : g_in
    assign k_in_tvalid[i] = ~lane_empty[i];
    assign lane_pop[i]    = k_in_tvalid[i] & k_in_tready[i];

    lii_lane_fifo #(.W(IW), .DEPTH(DEPTH)) u_fifo (
      .clk     (aclk),
      .rst     (arst),
      .push_i  (in_hs),
      .wdat_i  (lii_in_tdata[i*IW +: IW]),
      .pop_i   (lane_pop[i]),
      .rdat_o  (k_in_tdata[i*IW +: IW]),
      .empty_o (lane_empty[i]),
      .full_o  (lane_full[i])
    );
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      drop_cnt_q <= '0;
    end else if (drop_beat && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
  assign drop_cnt = drop_cnt_q;

  logic [NOUT-1:0]    held_q, held_d, kout_hs;
  logic [NOUT*OW-1:0] hold_q;
  logic [PW-1:0]      join_dat, out_dat_q;
  logic               out_vld_q, all_held, transfer;

  // A lane may refill its holding register in the same cycle it is drained.
  assign all_held     = &held_q;
  assign transfer     = all_held & (~out_vld_q | lii_out_tready);
  assign k_out_tready = ~held_q | {NOUT{transfer}};
  assign kout_hs      = k_out_tvalid & k_out_tready;
  assign held_d       = kout_hs | (held_q & ~{NOUT{transfer}});

  always_comb begin
    join_dat = '0;
    join_dat[NOUT*OW-1:0] = hold_q;
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      held_q <= '0;
      hold_q <= '0;
    end else begin
      held_q <= held_d;
      for (int j = 0; j < NOUT; j++) begin
        if (kout_hs[j]) hold_q[j*OW +: OW] <= k_out_tdata[j*OW +: OW];
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else if (transfer) begin
      out_vld_q <= 1'b1;
      out_dat_q <= join_dat;
    end else if (lii_out_tready) begin
      out_vld_q <= 1'b0;
    end
  end

  assign lii_out_tvalid = out_vld_q;
  assign lii_out_tdata  = out_dat_q;
  assign lii_out_src    = NODE_ID;
  assign lii_out_dst    = DEST_ID;
  assign ce             = ~(out_vld_q & ~lii_out_tready) & ~(all_held & ~transfer);
endmodule

// File: tb/tb_lii_stream_adapter.sv
// Randomized bench for lii_stream_adapter: per-lane queues model the lane FIFOs and the output join.
module tb_lii_stream_adapter;
  localparam int         NIN     = 5;
  localparam int         NOUT    = 2;
  localparam int         IW      = 17;
  localparam int         OW      = 32;
  localparam int         PW      = 128;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] NODE_ID = 8'h00;
  localparam logic [7:0] DEST_ID = 8'h3C;

  logic                aclk = 1'b0;
  logic                arst;
  logic [PW-1:0]       lii_in_tdata;
  logic                lii_in_tvalid, lii_in_tready;
  logic [7:0]          lii_in_src, lii_in_dst;
  logic [PW-1:0]       lii_out_tdata;
  logic                lii_out_tvalid, lii_out_tready;
  logic [7:0]          lii_out_src, lii_out_dst;
  logic [NIN*IW-1:0]   k_in_tdata;
  logic [NIN-1:0]      k_in_tvalid, k_in_tready;
  logic [NOUT*OW-1:0]  k_out_tdata;
  logic [NOUT-1:0]     k_out_tvalid, k_out_tready;
  logic [15:0]         drop_cnt;
  logic                ce;

  always #5 aclk = ~aclk;

  lii_stream_adapter #(
    .NIN(NIN), .NOUT(NOUT), .IW(IW), .OW(OW), .PW(PW), .DEPTH(DEPTH),
    .NODE_ID(NODE_ID), .DEST_ID(DEST_ID)
  ) dut (
    .aclk(aclk), .arst(arst),
    .lii_in_tdata(lii_in_tdata), .lii_in_tvalid(lii_in_tvalid), .lii_in_tready(lii_in_tready),
    .lii_in_src(lii_in_src), .lii_in_dst(lii_in_dst),
    .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid), .lii_out_tready(lii_out_tready),
    .lii_out_src(lii_out_src), .lii_out_dst(lii_out_dst),
    .k_in_tdata(k_in_tdata), .k_in_tvalid(k_in_tvalid), .k_in_tready(k_in_tready),
    .k_out_tdata(k_out_tdata), .k_out_tvalid(k_out_tvalid), .k_out_tready(k_out_tready),
    .drop_cnt(drop_cnt), .ce(ce)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state: values each kernel lane still has to see, values each
  // output lane has handed over but not yet seen leave on LII.
  logic [IW-1:0] inq   [NIN][$];
  logic [OW-1:0] sentq [NOUT][$];
  bit            exp_ov;
  int            exp_drop;
  bit            just_reset;
  int            accepted;

  int            p_in, p_foreign, p_kin, p_kout, p_ordy;
  int            force_dst;
  logic [NIN-1:0] kin_block;
  bit            fixed_pat;

  function automatic bit pct(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  task automatic step(input bit rst);
    logic [127:0]    d, e;
    logic [NOUT-1:0] kout_rdy_e;
    bit              own, in_rdy_e, allheld, xfer;
    int              held;

    @(negedge aclk);
    if (just_reset) begin
      check_eq("rst_tdata", lii_out_tdata, '0);
      check_eq("rst_in_rdy", lii_in_tready, 1);
      check_eq("rst_kout_rdy", k_out_tready, {NOUT{1'b1}});
      check_eq("rst_ce", ce, 1);
      just_reset = 0;
    end
    check_eq("drop_cnt", drop_cnt, exp_drop);
    check_eq("out_vld", lii_out_tvalid, exp_ov);
    check_eq("out_src", lii_out_src, NODE_ID);
    check_eq("out_dst", lii_out_dst, DEST_ID);
    if (exp_ov) begin
      e = '0;
      for (int j = 0; j < NOUT; j++) e[j*OW +: OW] = sentq[j][0];
      check_eq("out_dat", lii_out_tdata, e);
    end
    for (int i = 0; i < NIN; i++) begin
      check_eq("kin_vld", k_in_tvalid[i], inq[i].size() != 0);
      if (inq[i].size() != 0) check_eq("kin_dat", k_in_tdata[i*IW +: IW], inq[i][0]);
    end

    if (rst) begin
      arst = 1'b1;
      lii_in_tvalid = 1'b0;
      lii_in_dst = NODE_ID;
      k_in_tready = '0;
      k_out_tvalid = '0;
      lii_out_tready = 1'b1;
      for (int i = 0; i < NIN; i++) inq[i].delete();
      for (int j = 0; j < NOUT; j++) sentq[j].delete();
      exp_ov = 0;
      exp_drop = 0;
      just_reset = 1;
      return;
    end

    arst = 1'b0;
    d = {$urandom, $urandom, $urandom, $urandom};
    if (fixed_pat) for (int i = 0; i < NIN; i++) d[i*IW +: IW] = IW'(i + 1);
    own = (force_dst == 0) ? 1'b1 : (force_dst == 1) ? 1'b0 : !pct(p_foreign);
    lii_in_tdata  = d;
    lii_in_tvalid = pct(p_in);
    lii_in_src    = 8'($urandom);
    lii_in_dst    = own ? NODE_ID : NODE_ID + 8'(1 + $urandom_range(254));
    for (int i = 0; i < NIN; i++) k_in_tready[i] = pct(p_kin) & ~kin_block[i];
    for (int j = 0; j < NOUT; j++) k_out_tvalid[j] = pct(p_kout);
    k_out_tdata    = {$urandom, $urandom};
    lii_out_tready = pct(p_ordy);
    #1;

    in_rdy_e = 1;
    if (own) for (int i = 0; i < NIN; i++) if (inq[i].size() >= DEPTH) in_rdy_e = 0;
    check_eq("in_rdy", lii_in_tready, in_rdy_e);

    allheld = 1;
    for (int j = 0; j < NOUT; j++) begin
      held = sentq[j].size() - int'(exp_ov);
      if (held == 0) allheld = 0;
    end
    xfer = allheld & (!exp_ov | lii_out_tready);
    for (int j = 0; j < NOUT; j++) begin
      held = sentq[j].size() - int'(exp_ov);
      kout_rdy_e[j] = (held == 0) | xfer;
    end
    check_eq("kout_rdy", k_out_tready, kout_rdy_e);
    check_eq("ce", ce, !(exp_ov & !lii_out_tready));

    for (int i = 0; i < NIN; i++) if (inq[i].size() != 0 && k_in_tready[i]) void'(inq[i].pop_front());
    if (lii_in_tvalid && own && in_rdy_e) begin
      accepted++;
      for (int i = 0; i < NIN; i++) inq[i].push_back(d[i*IW +: IW]);
    end
    if (lii_in_tvalid && !own && exp_drop < 65535) exp_drop++;
    if (exp_ov && lii_out_tready) for (int j = 0; j < NOUT; j++) void'(sentq[j].pop_front());
    for (int j = 0; j < NOUT; j++)
      if (k_out_tvalid[j] && kout_rdy_e[j]) sentq[j].push_back(k_out_tdata[j*OW +: OW]);
    exp_ov = xfer | (exp_ov & !lii_out_tready);
  endtask

  initial begin
    int a0;
    arst = 1'b1;
    lii_in_tdata = '0; lii_in_tvalid = 1'b0; lii_in_src = '0; lii_in_dst = NODE_ID;
    k_in_tready = '0; k_out_tdata = '0; k_out_tvalid = '0; lii_out_tready = 1'b1;
    exp_ov = 0; exp_drop = 0; just_reset = 1; accepted = 0;
    p_in = 0; p_foreign = 0; p_kin = 100; p_kout = 0; p_ordy = 100;
    force_dst = 0; kin_block = '0; fixed_pat = 1;
    @(posedge aclk);
    #1;
    step(1);

    // Sustained own traffic with every sink ready.
    p_in = 100; p_kout = 100;
    a0 = accepted;
    repeat (100) step(0);
    check_eq("sustain_100", accepted - a0, 100);

    // One lagging lane fills its FIFO and backpressures the whole beat.
    p_in = 0; p_kout = 0;
    repeat (2) step(0);
    fixed_pat = 0;
    kin_block = 5'b00100; p_in = 100;
    a0 = accepted;
    repeat (10) step(0);
    check_eq("skew_accept", accepted - a0, DEPTH);
    kin_block = '0; p_in = 0;
    repeat (8) step(0);

    // Foreign beats interleaved with own beats.
    step(1);
    p_in = 100;
    for (int k = 0; k < 6; k++) begin
      force_dst = k % 2;
      step(0);
    end
    @(posedge aclk);
    #1;
    check_eq("drop_3", drop_cnt, 3);

    force_dst = -1;
    for (int blk = 0; blk < 30; blk++) begin
      p_in = $urandom_range(100); p_foreign = $urandom_range(50);
      p_kin = $urandom_range(100, 20); p_kout = $urandom_range(100);
      p_ordy = $urandom_range(100, 10);
      repeat (100) step(0);
    end

    // Output stall with a full join, FIFOs loaded, then reset mid-operation.
    force_dst = 0; p_in = 100; p_kin = 0; p_kout = 100; p_ordy = 0;
    repeat (6) step(0);
    check_eq("stall_ce", ce, 0);
    check_eq("stall_kout_rdy", k_out_tready, '0);
    check_eq("stall_in_full", lii_in_tready, 0);
    step(1);
    force_dst = -1; p_in = 70; p_foreign = 20; p_kin = 70; p_kout = 70; p_ordy = 70;
    repeat (500) step(0);

    // Drop counter saturation.
    step(1);
    force_dst = 1; p_in = 100;
    repeat (65540) step(0);
    @(posedge aclk);
    #1;
    check_eq("drop_sat", drop_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
